// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, fills the IF/ID register.
// Latency: an address presented at posedge k is captured in IF/ID at posedge k+1; one instruction per cycle.
// Backpressure: stall holds the PC and IF/ID; saltar overrides stall and inserts a bubble; HLT freezes the PC.
//
// Ports:
//   clk, reset_n          clock (posedge) and asynchronous active-low reset
//   stall                 hazard unit hold request
//   saltar, destino_salto taken branch/jump and its target word address
//   instruccion           word returned by instruction memory (read on negedge)
//   direccion             word address to instruction memory (the PC register)
//   if_id_*               IF/ID pipeline register: instruction, PC+1, valid flag
//   detenido              fetch halted after an HLT (all-zero word)
module etapa_fetch #(
    parameter int unsigned               ANCHO_PC = 10,
    parameter logic [ANCHO_PC-1:0]       PC_RESET = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                saltar,
    input  logic [ANCHO_PC-1:0] destino_salto,
    input  logic [31:0]         instruccion,
    output logic [ANCHO_PC-1:0] direccion,
    output logic [31:0]         if_id_instruccion,
    output logic [ANCHO_PC-1:0] if_id_pc_mas1,
    output logic                if_id_valido,
    output logic                detenido
);

    typedef enum logic [1:0] {
        ARRANQUE   = 2'd0,
        EJECUTANDO = 2'd1,
        DETENIDO   = 2'd2
    } estado_t;

    localparam logic [ANCHO_PC-1:0] UNO = {{(ANCHO_PC-1){1'b0}}, 1'b1};

    estado_t               estado_q, estado_d;
    logic [ANCHO_PC-1:0]   pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [ANCHO_PC-1:0]   pc_mas1_q, pc_mas1_d;
    logic                  valido_q, valido_d;

    // Wraps modulo 2^ANCHO_PC by construction.
    logic [ANCHO_PC-1:0]   pc_inc;
    assign pc_inc = pc_q + UNO;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= ARRANQUE;
            pc_q      <= PC_RESET;
            instr_q   <= '0;
            pc_mas1_q <= '0;
            valido_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_mas1_q <= pc_mas1_d;
            valido_q  <= valido_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        estado_d  = estado_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_mas1_d = pc_mas1_q;
        valido_d  = valido_q;

        unique case (estado_q)
            // One settling cycle so memory[PC_RESET] gets a full negedge read
            // no matter where in the cycle reset_n was released.
            ARRANQUE: begin
                estado_d = EJECUTANDO;
            end

            EJECUTANDO: begin
                if (saltar) begin
                    // Fetched word is wrong-path: drop it, no HLT check.
                    pc_d      = destino_salto;
                    instr_d   = '0;
                    pc_mas1_d = '0;
                    valido_d  = 1'b0;
                end else if (!stall) begin
                    instr_d   = instruccion;
                    pc_mas1_d = pc_inc;
                    valido_d  = 1'b1;
                    if (instruccion == 32'h0) begin
                        // HLT is passed downstream as valid; the PC parks on it.
                        estado_d = DETENIDO;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end

            DETENIDO: begin
                if (saltar) begin
                    pc_d      = destino_salto;
                    instr_d   = '0;
                    pc_mas1_d = '0;
                    valido_d  = 1'b0;
                    estado_d  = EJECUTANDO;
                end else if (!stall) begin
                    instr_d   = '0;
                    pc_mas1_d = '0;
                    valido_d  = 1'b0;
                end
            end

            default: begin
                estado_d = ARRANQUE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        direccion         = pc_q;
        if_id_instruccion = instr_q;
        if_id_pc_mas1     = pc_mas1_q;
        if_id_valido      = valido_q;
        detenido          = (estado_q == DETENIDO);
    end

endmodule

// File: tb/tb_etapa_fetch.sv
module tb_etapa_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: PC_RESET = 0
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        saltar = 1'b0;
    logic [9:0]  destino_salto = '0;
    logic [31:0] instruccion = '0;
    logic [9:0]  direccion;
    logic [31:0] if_id_instruccion;
    logic [9:0]  if_id_pc_mas1;
    logic        if_id_valido;
    logic        detenido;

    // Instance 2: PC_RESET = 1022, exercises wrap-around
    logic        reset_n2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        saltar2 = 1'b0;
    logic [9:0]  destino_salto2 = '0;
    logic [31:0] instruccion2 = '0;
    logic [9:0]  direccion2;
    logic [31:0] if_id_instruccion2;
    logic [9:0]  if_id_pc_mas1_2;
    logic        if_id_valido2;
    logic        detenido2;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem2 [0:1023];

    int errors = 0;
    int checks = 0;

    etapa_fetch #(.ANCHO_PC(10), .PC_RESET(10'd0)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall             (stall),
        .saltar            (saltar),
        .destino_salto     (destino_salto),
        .instruccion       (instruccion),
        .direccion         (direccion),
        .if_id_instruccion (if_id_instruccion),
        .if_id_pc_mas1     (if_id_pc_mas1),
        .if_id_valido      (if_id_valido),
        .detenido          (detenido)
    );

    etapa_fetch #(.ANCHO_PC(10), .PC_RESET(10'd1022)) dut_wrap (
        .clk               (clk),
        .reset_n           (reset_n2),
        .stall             (stall2),
        .saltar            (saltar2),
        .destino_salto     (destino_salto2),
        .instruccion       (instruccion2),
        .direccion         (direccion2),
        .if_id_instruccion (if_id_instruccion2),
        .if_id_pc_mas1     (if_id_pc_mas1_2),
        .if_id_valido      (if_id_valido2),
        .detenido          (detenido2)
    );

    // Instruction memories: registered read on the falling edge.
    always @(negedge clk) begin
        instruccion  <= mem1[direccion];
        instruccion2 <= mem2[direccion2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [9:0] pcm1,
                            input logic vld, input logic [9:0] dir, input logic det);
        chk({tag, ".instr"},  if_id_instruccion, ins);
        chk({tag, ".pcmas1"}, {22'd0, if_id_pc_mas1}, {22'd0, pcm1});
        chk({tag, ".valido"}, {31'd0, if_id_valido}, {31'd0, vld});
        chk({tag, ".dir"},    {22'd0, direccion}, {22'd0, dir});
        chk({tag, ".det"},    {31'd0, detenido}, {31'd0, det});
    endtask

    task automatic chk_wrap(input string tag, input logic [31:0] ins, input logic [9:0] pcm1,
                            input logic vld, input logic [9:0] dir);
        chk({tag, ".instr"},  if_id_instruccion2, ins);
        chk({tag, ".pcmas1"}, {22'd0, if_id_pc_mas1_2}, {22'd0, pcm1});
        chk({tag, ".valido"}, {31'd0, if_id_valido2}, {31'd0, vld});
        chk({tag, ".dir"},    {22'd0, direccion2}, {22'd0, dir});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'h0;
            mem2[i] = 32'h0;
        end
        mem1[0] = 32'h00221820;
        mem1[1] = 32'h00222020;
        mem1[2] = 32'h00222820;
        mem1[3] = 32'h00223020;
        mem1[4] = 32'hAC230000;
        mem1[5] = 32'h8C220000;
        mem2[1022] = 32'h11111111;
        mem2[1023] = 32'h22222222;
        mem2[0]    = 32'h33333333;
        mem2[1]    = 32'h44444444;

        // Reset state
        step();
        step();
        chk_ifid("reset", 32'h0, 10'd0, 1'b0, 10'd0, 1'b0);
        chk_wrap("reset2", 32'h0, 10'd0, 1'b0, 10'd1022);

        // Release mid-cycle, then one ARRANQUE cycle with a bubble
        #2 reset_n = 1'b1;
        step();
        chk_ifid("arranque", 32'h0, 10'd0, 1'b0, 10'd0, 1'b0);

        // Sequential fetch
        step(); chk_ifid("seq1", 32'h00221820, 10'd1, 1'b1, 10'd1, 1'b0);
        step(); chk_ifid("seq2", 32'h00222020, 10'd2, 1'b1, 10'd2, 1'b0);

        // Stall for two cycles
        stall = 1'b1;
        step(); chk_ifid("stall1", 32'h00222020, 10'd2, 1'b1, 10'd2, 1'b0);
        step(); chk_ifid("stall2", 32'h00222020, 10'd2, 1'b1, 10'd2, 1'b0);
        stall = 1'b0;
        step(); chk_ifid("seq3", 32'h00222820, 10'd3, 1'b1, 10'd3, 1'b0);
        step(); chk_ifid("seq4", 32'h00223020, 10'd4, 1'b1, 10'd4, 1'b0);

        // Redirect wins over stall
        saltar = 1'b1; stall = 1'b1; destino_salto = 10'd1;
        step(); chk_ifid("redir", 32'h0, 10'd0, 1'b0, 10'd1, 1'b0);
        saltar = 1'b0; stall = 1'b0;
        step(); chk_ifid("redir_next", 32'h00222020, 10'd2, 1'b1, 10'd2, 1'b0);
        step(); chk_ifid("seq_r3", 32'h00222820, 10'd3, 1'b1, 10'd3, 1'b0);
        step(); chk_ifid("seq_r4", 32'h00223020, 10'd4, 1'b1, 10'd4, 1'b0);
        step(); chk_ifid("seq5", 32'hAC230000, 10'd5, 1'b1, 10'd5, 1'b0);
        step(); chk_ifid("seq6", 32'h8C220000, 10'd6, 1'b1, 10'd6, 1'b0);

        // HLT at address 6
        step(); chk_ifid("hlt", 32'h0, 10'd7, 1'b1, 10'd6, 1'b1);
        step(); chk_ifid("halt_idle1", 32'h0, 10'd0, 1'b0, 10'd6, 1'b1);
        step(); chk_ifid("halt_idle2", 32'h0, 10'd0, 1'b0, 10'd6, 1'b1);

        // Leave halt by redirect to 0
        saltar = 1'b1; destino_salto = 10'd0;
        step(); chk_ifid("unhalt", 32'h0, 10'd0, 1'b0, 10'd0, 1'b0);
        saltar = 1'b0;
        step(); chk_ifid("post_halt1", 32'h00221820, 10'd1, 1'b1, 10'd1, 1'b0);
        step(); chk_ifid("post_halt2", 32'h00222020, 10'd2, 1'b1, 10'd2, 1'b0);
        step(); chk_ifid("post_halt3", 32'h00222820, 10'd3, 1'b1, 10'd3, 1'b0);

        // Asynchronous reset between clock edges
        #2 reset_n = 1'b0;
        #1 chk_ifid("async_rst", 32'h0, 10'd0, 1'b0, 10'd0, 1'b0);
        #3 reset_n = 1'b1;
        step(); chk_ifid("arranque2", 32'h0, 10'd0, 1'b0, 10'd0, 1'b0);
        step(); chk_ifid("restart1", 32'h00221820, 10'd1, 1'b1, 10'd1, 1'b0);

        // Wrap-around on the second instance
        reset_n2 = 1'b1;
        step(); chk_wrap("wrap_arr", 32'h0, 10'd0, 1'b0, 10'd1022);
        step(); chk_wrap("wrap1", 32'h11111111, 10'd1023, 1'b1, 10'd1023);
        step(); chk_wrap("wrap2", 32'h22222222, 10'd0, 1'b1, 10'd0);
        step(); chk_wrap("wrap3", 32'h33333333, 10'd1, 1'b1, 10'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/etapa_fetch.md
Name: etapa_fetch

Overview:
Instruction-fetch stage of the 5-stage pipeline. Owns the PC, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. The memory reads on the falling edge, so the addressed word is valid by the next rising edge. Handles stall, branch/jump redirect with bubble insertion, and halt on HLT (all-zero word).

Parameters:
ANCHO_PC, 10, PC/word-address width; must match the instruction-memory address width.
PC_RESET, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset_n  in  1  asynchronous, active-low reset.
stall  in  1  hazard unit: hold PC and IF/ID.
saltar  in  1  taken branch/jump resolved downstream; redirect this cycle.
destino_salto  in  ANCHO_PC  redirect target word address.
instruccion  in  32  word from instruction memory (registered there on negedge).
direccion  out  ANCHO_PC  address to instruction memory; equals the PC register.
if_id_instruccion  out  32  IF/ID instruction.
if_id_pc_mas1  out  ANCHO_PC  IF/ID PC+1 of the captured instruction.
if_id_valido  out  1  IF/ID holds a real instruction (0 = bubble).
detenido  out  1  fetch halted on HLT.

Behaviour:
- Reset (async, reset_n=0): PC=PC_RESET, if_id_instruccion=0, if_id_pc_mas1=0, if_id_valido=0, detenido=0, state ARRANQUE. Reset mid-operation discards all in-flight state immediately.
- direccion is combinational from PC only; no other logic drives it.
- States: ARRANQUE, EJECUTANDO, DETENIDO. detenido=1 iff state is DETENIDO.
- ARRANQUE: exactly one posedge after reset release. PC held, IF/ID held at bubble, next state EJECUTANDO. This guarantees a full negedge read of memory[PC_RESET] regardless of when reset_n is released. saltar and stall are ignored in this state.
- EJECUTANDO: per posedge, priority saltar > stall > normal:
  - saltar=1: PC<=destino_salto; IF/ID<=bubble (instr 0, valido 0, pc_mas1 0). Applies even if stall=1. HLT detection is suppressed because the fetched word is wrong-path.
  - stall=1: PC and all IF/ID outputs hold.
  - normal: IF/ID<={instruccion, PC+1, valido 1}; PC<=PC+1. If instruccion==32'h0 (HLT), PC holds instead and next state is DETENIDO. The HLT itself is captured with valido=1.
- DETENIDO: PC holds. Priority saltar > stall > idle:
  - saltar=1: PC<=destino_salto, IF/ID<=bubble, next state EJECUTANDO.
  - stall=1: IF/ID holds.
  - idle: IF/ID<=bubble every posedge.
- Arithmetic: PC+1 is modulo 2^ANCHO_PC (1023+1 -> 0 at ANCHO_PC=10). if_id_pc_mas1 wraps identically.
- Latency: an address presented at posedge k appears in IF/ID at posedge k+1. Sustained throughput is one instruction per cycle.

Test Plan:
- Sequential fetch, memory 0x00221820, 0x00222020, 0x00222820, 0x00223020, 0xAC230000, 0x8C220000, then zeros.
  - After release: one ARRANQUE cycle with valido=0.
  - Then IF/ID shows those words on consecutive cycles with pc_mas1=1..6 and valido=1.
- Stall: stall=1 for 2 cycles while IF/ID holds 0x00222020 (pc_mas1=2) -> IF/ID and direccion=2 frozen for 2 cycles. Next cycle shows 0x00222820, pc_mas1=3.
- Redirect with stall: saltar=1, stall=1, destino_salto=1 while direccion=4 -> next cycle direccion=1 and valido=0. The cycle after shows 0x00222020, pc_mas1=2.
- HLT: fetch reaches address 6 (word 0) -> IF/ID=0 with valido=1 and pc_mas1=7; detenido=1; direccion stays 6; following cycles valido=0. Then saltar=1, destino_salto=0 -> detenido=0, and 0x00221820 fetched next.
- Wrap: PC_RESET=1022 with nonzero words at 1022, 1023, 0 -> pc_mas1 sequence 1023, 0, 1; direccion goes 1022 -> 1023 -> 0 -> 1.
- Async reset mid-run: reset_n low between clock edges while direccion=3 and valido=1 -> immediately direccion=0, valido=0, IF/ID=0, detenido=0. ARRANQUE repeats after release.
